// File: rtl/pwm_gen_pkg.sv
// Shared types and constants for the PWM counter/compare engine.
package pwm_gen_pkg;

  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_STOPPING} pwm_state_t;

  // Bit positions inside the ctrl register
  localparam int unsigned CTRL_EN_BIT  = 0;
  localparam int unsigned CTRL_POL_BIT = 1;

  // Register file byte offsets
  localparam logic [3:0] REG_CTRL     = 4'h0;
  localparam logic [3:0] REG_PERIOD   = 4'h4;
  localparam logic [3:0] REG_DUTY     = 4'h8;
  localparam logic [3:0] REG_PRESCALE = 4'hC;

endpackage

// File: rtl/pwm_gen_core_if.sv
// Config/status bundle between the AXI4-Lite register file (master) and the PWM engine (slave).
// Optional macro PWM_GEN_IRQ_EN adds cfg_irq_en, irq_clr and irq.
interface pwm_gen_core_if #(
  parameter int unsigned C_CNT_WIDTH      = 32,
  parameter int unsigned C_PRESCALE_WIDTH = 16
);
  logic                        cfg_enable;
  logic                        cfg_polarity;
  logic [C_CNT_WIDTH-1:0]      cfg_period;
  logic [C_CNT_WIDTH-1:0]      cfg_duty;
  logic [C_PRESCALE_WIDTH-1:0] cfg_prescale;
  logic                        cfg_update;
  logic                        pwm_out;
  logic                        period_end;
  logic                        busy;
  logic [C_CNT_WIDTH-1:0]      cnt_value;
`ifdef PWM_GEN_IRQ_EN
  logic                        cfg_irq_en;
  logic                        irq_clr;
  logic                        irq;
`endif

  modport master (
`ifdef PWM_GEN_IRQ_EN
    output cfg_irq_en, output irq_clr, input irq,
`endif
    output cfg_enable, output cfg_polarity, output cfg_period, output cfg_duty,
    output cfg_prescale, output cfg_update,
    input pwm_out, input period_end, input busy, input cnt_value
  );

  modport slave (
`ifdef PWM_GEN_IRQ_EN
    input cfg_irq_en, input irq_clr, output irq,
`endif
    input cfg_enable, input cfg_polarity, input cfg_period, input cfg_duty,
    input cfg_prescale, input cfg_update,
    output pwm_out, output period_end, output busy, output cnt_value
  );

endinterface

// File: rtl/pwm_prescaler.sv
// Clock prescaler: holds the prescale shadow and emits a tick every presc_sh+1 clocks.
module pwm_prescaler #(
  parameter int unsigned C_PRESCALE_WIDTH = 16
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        en,
  input  logic                        load,
  input  logic [C_PRESCALE_WIDTH-1:0] load_val,
  output logic                        tick
);

  logic [C_PRESCALE_WIDTH-1:0] presc_cnt_q;
  logic [C_PRESCALE_WIDTH-1:0] presc_sh_q;

  assign tick = en && (presc_cnt_q == presc_sh_q);

  // Shadow reload and divide counter; the counter is held at zero while disabled
  always_ff @(posedge clk) begin
    if (rst) begin
      presc_cnt_q <= '0;
      presc_sh_q  <= '0;
    end else begin
      if (load) begin
        presc_sh_q <= load_val;
      end
      if (!en || tick) begin
        presc_cnt_q <= '0;
      end else begin
        presc_cnt_q <= presc_cnt_q + C_PRESCALE_WIDTH'(1);
      end
    end
  end

endmodule

// File: rtl/pwm_gen_core.sv
// PWM counter/compare engine with double-buffered period/duty/prescale.
// Config changes written while running are held pending and applied only at end of period.
// Optional macro PWM_GEN_IRQ_EN adds a sticky period-end interrupt (irq, irq_clr, cfg_irq_en).
module pwm_gen_core
  import pwm_gen_pkg::*;
#(
  parameter int unsigned C_CNT_WIDTH      = 32,
  parameter int unsigned C_PRESCALE_WIDTH = 16
) (
  input  logic          ACLK,
  input  logic          ARESET,
  pwm_gen_core_if.slave bus
);

  pwm_state_t             state_q;
  logic [C_CNT_WIDTH-1:0] period_sh_q;
  logic [C_CNT_WIDTH-1:0] duty_sh_q;
  logic [C_CNT_WIDTH-1:0] cnt_q;
  logic                   pending_q;
  logic                   pwm_out_q;
  logic                   period_end_q;

  logic running;
  logic start;
  logic tick;
  logic eop;
  logic reload;

  assign running = (state_q != ST_IDLE);
  assign start   = (state_q == ST_IDLE) && bus.cfg_enable;
  assign eop     = running && tick && (cnt_q == period_sh_q);
  // An update strobe landing on the last tick counts as pending
  assign reload  = eop && (pending_q || bus.cfg_update);

  pwm_prescaler #(
    .C_PRESCALE_WIDTH(C_PRESCALE_WIDTH)
  ) u_prescaler (
    .clk     (ACLK),
    .rst     (ARESET),
    .en      (running),
    .load    (start || reload),
    .load_val(bus.cfg_prescale),
    .tick    (tick)
  );

  // Control FSM, period counter, shadows and registered outputs
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      state_q      <= ST_IDLE;
      period_sh_q  <= '0;
      duty_sh_q    <= '0;
      cnt_q        <= '0;
      pending_q    <= 1'b0;
      pwm_out_q    <= 1'b0;
      period_end_q <= 1'b0;
    end else begin
      pwm_out_q    <= (running && (cnt_q < duty_sh_q)) ^ bus.cfg_polarity;
      period_end_q <= eop;
      if (start || reload) begin
        period_sh_q <= bus.cfg_period;
        duty_sh_q   <= bus.cfg_duty;
      end
      case (state_q)
        ST_IDLE: begin
          if (bus.cfg_enable) begin
            state_q   <= ST_RUN;
            cnt_q     <= '0;
            pending_q <= 1'b0;
          end
        end
        ST_RUN, ST_STOPPING: begin
          if (tick) begin
            cnt_q <= eop ? '0 : cnt_q + C_CNT_WIDTH'(1);
          end
          if (reload) begin
            pending_q <= 1'b0;
          end else if (bus.cfg_update) begin
            pending_q <= 1'b1;
          end
          if (state_q == ST_RUN) begin
            if (!bus.cfg_enable) state_q <= ST_STOPPING;
          end else if (bus.cfg_enable) begin
            state_q <= ST_RUN;
          end else if (eop) begin
            state_q <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign bus.pwm_out    = pwm_out_q;
  assign bus.period_end = period_end_q;
  assign bus.busy       = running;
  assign bus.cnt_value  = cnt_q;

`ifdef PWM_GEN_IRQ_EN
  logic irq_q;

  // Sticky interrupt: set by the period_end pulse, set wins over a coincident clear
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      irq_q <= 1'b0;
    end else if (period_end_q && bus.cfg_irq_en) begin
      irq_q <= 1'b1;
    end else if (bus.irq_clr) begin
      irq_q <= 1'b0;
    end
  end

  assign bus.irq = irq_q && bus.cfg_irq_en;
`endif

endmodule

// File: tb/tb_pwm_gen_core.sv
// Self-checking bench for pwm_gen_core: directed scenarios with literal expectations plus
// randomized stimulus compared every cycle against an arithmetic period/tick model.
module tb_pwm_gen_core;
  import pwm_gen_pkg::*;

  localparam int unsigned CW = 32;
  localparam int unsigned PW = 16;
  localparam int M_IDLE = 0;
  localparam int M_RUN  = 1;
  localparam int M_STOP = 2;

  logic aclk = 1'b0;
  logic areset = 1'b1;

  pwm_gen_core_if #(.C_CNT_WIDTH(CW), .C_PRESCALE_WIDTH(PW)) bus ();

  pwm_gen_core #(.C_CNT_WIDTH(CW), .C_PRESCALE_WIDTH(PW)) dut (
    .ACLK  (aclk),
    .ARESET(areset),
    .bus   (bus)
  );

  always #5 aclk = ~aclk;

  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at time %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: position in period counted in clocks since the period started
  int     m_state = M_IDLE;
  longint m_per = 0, m_duty = 0, m_presc = 0, m_el = 0;
  bit     m_pend = 0, m_valid = 0, m_eop = 0;
  bit     e_pwm = 0, e_pe = 0, e_irq_s = 0;

  task automatic model_load();
    m_per   = longint'(bus.cfg_period);
    m_duty  = longint'(bus.cfg_duty);
    m_presc = longint'(bus.cfg_prescale);
  endtask

  initial begin
    forever begin
      @(posedge aclk);
      if (areset) begin
        m_state = M_IDLE; m_per = 0; m_duty = 0; m_presc = 0; m_el = 0;
        m_pend = 0; e_pwm = 0; e_pe = 0; e_irq_s = 0; m_valid = 1;
      end else begin
`ifdef PWM_GEN_IRQ_EN
        if (e_pe && bus.cfg_irq_en) e_irq_s = 1;
        else if (bus.irq_clr) e_irq_s = 0;
`endif
        if (m_state == M_IDLE) begin
          e_pwm = bus.cfg_polarity;
          e_pe  = 0;
          if (bus.cfg_enable) begin
            m_state = M_RUN; model_load(); m_el = 0; m_pend = 0;
          end
        end else begin
          m_eop = (m_el + 1) == (m_per + 1) * (m_presc + 1);
          e_pwm = ((m_el / (m_presc + 1)) < m_duty) ^ bus.cfg_polarity;
          e_pe  = m_eop;
          if (m_eop) begin
            m_el = 0;
            if (m_pend || bus.cfg_update) begin
              model_load(); m_pend = 0;
            end
          end else begin
            m_el++;
            if (bus.cfg_update) m_pend = 1;
          end
          if (m_state == M_RUN) begin
            if (!bus.cfg_enable) m_state = M_STOP;
          end else if (bus.cfg_enable) m_state = M_RUN;
          else if (m_eop) m_state = M_IDLE;
        end
      end
    end
  end

  // Every-cycle comparison against the model, away from the active edge
  initial begin
    forever begin
      @(negedge aclk);
      if (m_valid) begin
        check("pwm_out", longint'(bus.pwm_out), longint'(e_pwm));
        check("period_end", longint'(bus.period_end), longint'(e_pe));
        check("busy", longint'(bus.busy), longint'(m_state != M_IDLE));
        check("cnt_value", longint'(bus.cnt_value), m_el / (m_presc + 1));
`ifdef PWM_GEN_IRQ_EN
        check("irq", longint'(bus.irq), longint'(e_irq_s && bus.cfg_irq_en));
`endif
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge aclk);
  endtask

  function automatic logic [31:0] ctrl_word(input logic en, input logic pol);
    logic [31:0] w;
    w = '0;
    w[CTRL_EN_BIT]  = en;
    w[CTRL_POL_BIT] = pol;
    return w;
  endfunction

  task automatic reg_write(input logic [3:0] addr, input logic [31:0] data);
    case (addr)
      REG_CTRL: begin
        bus.cfg_enable   = data[CTRL_EN_BIT];
        bus.cfg_polarity = data[CTRL_POL_BIT];
      end
      REG_PERIOD:   bus.cfg_period   = data;
      REG_DUTY:     bus.cfg_duty     = data;
      REG_PRESCALE: bus.cfg_prescale = data[PW-1:0];
      default: ;
    endcase
    bus.cfg_update = (addr != REG_CTRL);
    cyc(1);
    bus.cfg_update = 1'b0;
  endtask

  task automatic do_reset();
    areset = 1'b1;
    bus.cfg_enable = 1'b0;
    bus.cfg_update = 1'b0;
`ifdef PWM_GEN_IRQ_EN
    bus.irq_clr = 1'b0;
`endif
    cyc(2);
    areset = 1'b0;
  endtask

  task automatic start_run(input int per, input int duty, input int presc, input bit pol);
    reg_write(REG_PERIOD, 32'(per));
    reg_write(REG_DUTY, 32'(duty));
    reg_write(REG_PRESCALE, 32'(presc));
    reg_write(REG_CTRL, ctrl_word(1'b1, pol));
  endtask

  task automatic wait_cnt(input int target, input int budget);
    bit found;
    found = 0;
    for (int i = 0; i < budget; i++) begin
      if (bus.cnt_value == 32'(target)) begin
        found = 1;
        break;
      end
      cyc(1);
    end
    check("wait_cnt_reached", longint'(found), 1);
  endtask

  int hi, pes, bad, n;
  bit found;
  int unsigned rk;
  int b_per[3]  = '{9, 9, 0};
  int b_duty[3] = '{0, 15, 1};
  bit b_act[3]  = '{1'b0, 1'b1, 1'b1};

  initial begin
    bus.cfg_enable = 0; bus.cfg_polarity = 0; bus.cfg_period = '0; bus.cfg_duty = '0;
    bus.cfg_prescale = '0; bus.cfg_update = 0;
`ifdef PWM_GEN_IRQ_EN
    bus.cfg_irq_en = 0; bus.irq_clr = 0;
`endif
    cyc(3);
    check("rst_pwm", longint'(bus.pwm_out), 0);
    check("rst_period_end", longint'(bus.period_end), 0);
    check("rst_busy", longint'(bus.busy), 0);
    check("rst_cnt", longint'(bus.cnt_value), 0);
    areset = 1'b0;

    // Basic waveform: 3 high / 7 low, period_end every 10 clocks
    start_run(9, 3, 0, 1'b0);
    check("basic_first_low", longint'(bus.pwm_out), 0);
    hi = 0; pes = 0;
    for (int i = 0; i < 20; i++) begin
      cyc(1);
      if (i == 0) check("basic_first_high", longint'(bus.pwm_out), 1);
      hi += int'(bus.pwm_out);
      pes += int'(bus.period_end);
    end
    check("basic_high_clocks", hi, 6);
    check("basic_period_ends", pes, 2);

    // Glitch-free update: duty 7 written at cnt=5 applies next period only
    wait_cnt(5, 20);
    reg_write(REG_DUTY, 32'd7);
    hi = 0; found = 0;
    for (int i = 0; i < 20; i++) begin
      if (bus.period_end) begin
        found = 1;
        break;
      end
      hi += int'(bus.pwm_out);
      cyc(1);
    end
    check("glitch_period_end_seen", longint'(found), 1);
    check("glitch_old_period_high", hi, 0);
    hi = 0;
    for (int i = 0; i < 10; i++) begin
      cyc(1);
      hi += int'(bus.pwm_out);
    end
    check("glitch_new_period_high", hi, 7);

    // Prescale: 20-clock period, 10 high, counter steps every 5 clocks
    do_reset();
    start_run(3, 2, 4, 1'b0);
    hi = 0; pes = 0;
    for (int i = 0; i < 20; i++) begin
      cyc(1);
      if (i == 3) check("presc_cnt_before_step", longint'(bus.cnt_value), 0);
      if (i == 4) check("presc_cnt_after_step", longint'(bus.cnt_value), 1);
      hi += int'(bus.pwm_out);
      pes += int'(bus.period_end);
    end
    check("presc_high_clocks", hi, 10);
    check("presc_period_ends", pes, 1);

    // Boundaries under both polarities
    for (int p = 0; p < 2; p++) begin
      for (int c = 0; c < 3; c++) begin
        do_reset();
        reg_write(REG_CTRL, ctrl_word(1'b0, 1'(p)));
        check($sformatf("idle_level_pol%0d", p), longint'(bus.pwm_out), longint'(p));
        start_run(b_per[c], b_duty[c], 0, 1'(p));
        bad = 0; pes = 0;
        for (int i = 0; i < 20; i++) begin
          cyc(1);
          if (bus.pwm_out != (b_act[c] ^ 1'(p))) bad++;
          pes += int'(bus.period_end);
        end
        check($sformatf("bound_pwm_case%0d_pol%0d", c, p), bad, 0);
        if (c == 2) check($sformatf("bound_pe_every_clock_pol%0d", p), pes, 20);
      end
    end

    // Graceful stop: enable dropped at cnt=2 finishes the period
    do_reset();
    start_run(9, 3, 0, 1'b0);
    wait_cnt(2, 20);
    reg_write(REG_CTRL, ctrl_word(1'b0, 1'b0));
    n = 0;
    for (int i = 0; i < 20; i++) begin
      if (!bus.busy) break;
      n++;
      cyc(1);
    end
    check("stop_busy_clocks", n, 7);
    check("stop_final_period_end", longint'(bus.period_end), 1);
    check("stop_cnt_zero", longint'(bus.cnt_value), 0);
    cyc(1);
    check("stop_idle_level", longint'(bus.pwm_out), 0);

    // Mid-run reset clears everything on the next edge
    do_reset();
    start_run(9, 3, 0, 1'b1);
    wait_cnt(4, 20);
    areset = 1'b1;
    cyc(1);
    check("midrst_pwm", longint'(bus.pwm_out), 0);
    check("midrst_busy", longint'(bus.busy), 0);
    check("midrst_cnt", longint'(bus.cnt_value), 0);
    check("midrst_period_end", longint'(bus.period_end), 0);
    areset = 1'b0;
    cyc(1);
    check("midrst_idle_level", longint'(bus.pwm_out), 1);

`ifdef PWM_GEN_IRQ_EN
    // Sticky irq: set after period_end, set beats coincident clear, clear alone drops it
    do_reset();
    bus.cfg_irq_en = 1'b1;
    start_run(3, 1, 0, 1'b0);
    found = 0;
    for (int i = 0; i < 10; i++) begin
      if (bus.period_end) begin
        found = 1;
        break;
      end
      cyc(1);
    end
    check("irq_pe_seen", longint'(found), 1);
    cyc(1);
    check("irq_set", longint'(bus.irq), 1);
    found = 0;
    for (int i = 0; i < 10; i++) begin
      if (bus.period_end) begin
        found = 1;
        break;
      end
      cyc(1);
    end
    check("irq_pe2_seen", longint'(found), 1);
    bus.irq_clr = 1'b1;
    cyc(1);
    bus.irq_clr = 1'b0;
    check("irq_set_wins", longint'(bus.irq), 1);
    bus.irq_clr = 1'b1;
    cyc(1);
    bus.irq_clr = 1'b0;
    check("irq_cleared", longint'(bus.irq), 0);
`endif

    // Randomized phase checked by the model every cycle
    do_reset();
    for (int r = 0; r < 1500; r++) begin
      rk = $urandom_range(0, 99);
      areset = (rk < 2);
      bus.cfg_update = 1'b0;
      if (rk >= 2 && rk < 7) begin
        bus.cfg_enable = ~bus.cfg_enable;
      end else if (rk < 17) begin
        bus.cfg_period = $urandom_range(0, 6); bus.cfg_update = 1'b1;
      end else if (rk < 27) begin
        bus.cfg_duty = $urandom_range(0, 8); bus.cfg_update = 1'b1;
      end else if (rk < 32) begin
        bus.cfg_prescale = PW'($urandom_range(0, 3)); bus.cfg_update = 1'b1;
      end else if (rk < 34) begin
        bus.cfg_polarity = ~bus.cfg_polarity;
      end else if (rk == 50) begin
        bus.cfg_enable = 1'b1;
      end
`ifdef PWM_GEN_IRQ_EN
      bus.irq_clr = ($urandom_range(0, 7) == 0);
      if ($urandom_range(0, 49) == 0) bus.cfg_irq_en = ~bus.cfg_irq_en;
`endif
      cyc(1);
    end
    areset = 1'b0;
    bus.cfg_update = 1'b0;
    cyc(2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pwm_gen_core.md
Name: pwm_gen_core

Overview:
- Counter/compare engine downstream of the AXI4-Lite slave register file in the axi_pwm IP.
- Consumes four register-file outputs (ctrl, period, duty, prescale) plus a write-update strobe. Produces the PWM pin, a period-end pulse and status.
- Double-buffered (shadow) config, so software writes never glitch the waveform mid-period.

Parameters:
- C_CNT_WIDTH, 32, width of period/duty/counter.
- C_PRESCALE_WIDTH, 16, width of prescaler reload.

Ports:
- ACLK  in  1  system clock (AXI clock domain)
- ARESET  in  1  synchronous, active-high reset
- cfg_enable  in  1  ctrl[0]: run request
- cfg_polarity  in  1  ctrl[1]: 0 = active-high output, 1 = active-low output
- cfg_period  in  C_CNT_WIDTH  last counter value of a period (period length = value+1 ticks)
- cfg_duty  in  C_CNT_WIDTH  active ticks per period
- cfg_prescale  in  C_PRESCALE_WIDTH  tick every value+1 clocks
- cfg_update  in  1  1-cycle pulse: any period/duty/prescale register written
- pwm_out  out  1  PWM pin, registered
- period_end  out  1  1-cycle pulse on last tick of each period
- busy  out  1  state != IDLE
- cnt_value  out  C_CNT_WIDTH  current period counter, for status readback

Behaviour:
- Reset values: all outputs 0, shadows 0, counters 0, state IDLE, pending flag 0.
- FSM states:
  - IDLE → RUN when cfg_enable=1. On that edge: load shadows (period_sh, duty_sh, presc_sh) from cfg_*, set cnt=0, presc_cnt=0, clear pending.
  - RUN → STOPPING when cfg_enable=0. The period always completes; there is no abrupt stop.
  - STOPPING → RUN if cfg_enable returns to 1 before the period ends. No reload on this transition; pending rules apply.
  - STOPPING → IDLE on the end-of-period tick.
- Prescaler and tick:
  - tick = (presc_cnt == presc_sh). On tick, presc_cnt ← 0; otherwise presc_cnt increments.
  - presc_sh=0 gives a tick every clock.
- Period counter:
  - Advances only on tick, and only in RUN or STOPPING.
  - cnt == period_sh on tick: this is end-of-period. cnt ← 0, and period_end pulses high for 1 cycle (registered, asserted the cycle after the tick edge).
  - Otherwise cnt increments. Wrap compare is equality only; no overflow possible because period_sh is at most all-ones.
- Shadow update:
  - cfg_update in RUN or STOPPING sets pending.
  - At end-of-period, if pending, or if cfg_update is asserted in that same cycle: reload all three shadows and clear pending.
  - cfg_update in IDLE is ignored, because shadows are loaded on start anyway.
- Output:
  - active = (state != IDLE) && (cnt < duty_sh). Compare is unsigned and full width.
  - pwm_out ← active ^ cfg_polarity, registered, so it lags cnt by 1 clock.
  - In IDLE, pwm_out = cfg_polarity (inactive level); a polarity change takes effect next clock.
- Boundaries:
  - duty_sh=0 gives 0% (constant inactive).
  - duty_sh > period_sh gives 100% (constant active).
  - period_sh=0 with duty≥1 gives constant active, and period_end pulses every tick.
- cnt_value = cnt.
- ARESET mid-operation returns everything to reset values on the next edge, with no completion of the period.

Optional Feature:
- Macro: PWM_GEN_IRQ_EN.
- When defined, the block adds:
  - input irq_clr (1-bit).
  - output irq (1-bit), a sticky level: set the cycle after period_end, cleared by irq_clr. If set and clear coincide, set wins.
  - input cfg_irq_en; irq is masked by it, and reset value is 0.
- When undefined, these ports and the logic do not exist; behaviour is otherwise identical.

Decomposition:
- Package pwm_gen_pkg holds:
  - typedef enum logic[1:0] {ST_IDLE, ST_RUN, ST_STOPPING} pwm_state_t;
  - localparam bit positions CTRL_EN_BIT=0, CTRL_POL_BIT=1;
  - register offsets REG_CTRL=0x0, REG_PERIOD=0x4, REG_DUTY=0x8, REG_PRESCALE=0xC.
- Sub-module pwm_prescaler: presc_cnt, presc_sh reload, tick output, enable input.

Test Plan:
- Basic waveform: period=9, duty=3, prescale=0, pol=0, enable → pwm_out high 3 clocks, low 7; period_end every 10 clocks; first high 1 clock after enable edge.
- Prescale: period=3, duty=2, prescale=4 → 20-clock period, 10 high; cnt_value steps every 5 clocks.
- Glitch-free update: running period=9/duty=3, write duty=7 + cfg_update mid-period (cnt=5) → current period stays 3-high; next period 7-high.
- Boundaries:
  - duty=0 → pwm_out constantly 0.
  - duty=15, period=9 → constantly 1.
  - period=0, duty=1 → constantly 1, period_end every clock.
  - pol=1 inverts all three cases; IDLE level is 1.
- Graceful stop and reset:
  - Deassert enable at cnt=2 (period=9) → busy stays high until cnt=9 tick, then IDLE, pwm_out=pol.
  - Separately, assert ARESET at cnt=4 → next edge, all outputs 0, busy 0.
- With PWM_GEN_IRQ_EN: cfg_irq_en=1 → irq sets after first period_end and holds. irq_clr coincident with the next period_end → irq stays 1. irq_clr alone → irq 0.
